// File: rtl/sync_filter_bank.sv
// sync_filter_bank: per-channel multi-flop synchronizer with a stability filter and registered edge pulses.
module sync_filter_bank #(
    parameter int C_WIDTH = 1,
    parameter int C_NUM_LEVELS = 2,
    parameter int C_FILTER_CYCLES = 1,
    parameter logic [C_WIDTH-1:0] C_RST_VAL = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [C_WIDTH-1:0] i_data,
    output logic [C_WIDTH-1:0] o_data,
    output logic [C_WIDTH-1:0] o_rise,
    output logic [C_WIDTH-1:0] o_fall
);
    localparam int CW = $clog2(C_FILTER_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(C_FILTER_CYCLES - 1);
    logic [C_WIDTH-1:0] stage [C_NUM_LEVELS];
    logic [CW-1:0] cnt [C_WIDTH];
    logic [C_WIDTH-1:0] sync;
    assign sync = stage[C_NUM_LEVELS-1];
    // o_data is the stable state; it only moves after C_FILTER_CYCLES consecutive disagreeing samples
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < C_NUM_LEVELS; k++) stage[k] <= C_RST_VAL;
            for (int n = 0; n < C_WIDTH; n++) cnt[n] <= '0;
            o_data <= C_RST_VAL;
            o_rise <= '0;
            o_fall <= '0;
        end else begin
            stage[0] <= i_data;
            for (int k = 1; k < C_NUM_LEVELS; k++) stage[k] <= stage[k-1];
            for (int n = 0; n < C_WIDTH; n++) begin
                o_rise[n] <= 1'b0;
                o_fall[n] <= 1'b0;
                if (sync[n] == o_data[n]) begin
                    cnt[n] <= '0;
                end else if (cnt[n] == LAST) begin
                    cnt[n]    <= '0;
                    o_data[n] <= sync[n];
                    o_rise[n] <= sync[n];
                    o_fall[n] <= ~sync[n];
                end else begin
                    cnt[n] <= cnt[n] + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sync_filter_bank.sv
// tb_sync_filter_bank: randomized and directed check of two filter configurations against an input-history model.
module tb_sync_filter_bank;
    localparam int L = 2;
    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic [3:0] od0, or0, of0, od1, or1, of1;
    int checks = 0;
    int failures = 0;

    sync_filter_bank #(.C_WIDTH(4), .C_NUM_LEVELS(2), .C_FILTER_CYCLES(3), .C_RST_VAL(4'h0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_data(din), .o_data(od0), .o_rise(or0), .o_fall(of0));
    sync_filter_bank #(.C_WIDTH(4), .C_NUM_LEVELS(2), .C_FILTER_CYCLES(1), .C_RST_VAL(4'hF)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_data(din), .o_data(od1), .o_rise(or1), .o_fall(of1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: o_data flips once the last F synchronized samples since reset all disagree with it,
    // where the synchronized sample seen at edge e is the input sampled L edges earlier
    int         fc [2] = '{3, 1};
    logic [3:0] rv [2] = '{4'h0, 4'hF};
    logic [3:0] inp [8192];
    int         edge_n = 0;
    int         last_rst = -100;
    logic       armed = 1'b0;
    logic [3:0] m_o [2];
    logic [3:0] m_r [2];
    logic [3:0] m_f [2];

    always @(posedge clk) begin
        automatic int e = edge_n + 1;
        automatic logic [3:0] no, nr, nf, sv;
        automatic logic flip;
        edge_n <= e;
        inp[e] <= din;
        if (rst) begin
            last_rst <= e;
            armed <= 1'b1;
            for (int d = 0; d < 2; d++) begin
                m_o[d] <= rv[d];
                m_r[d] <= '0;
                m_f[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                no = m_o[d];
                nr = '0;
                nf = '0;
                for (int n = 0; n < 4; n++) begin
                    flip = 1'b1;
                    for (int k = 0; k < fc[d]; k++) begin
                        sv = (e - k - L > last_rst) ? inp[e-k-L] : rv[d];
                        if (e - k <= last_rst || sv[n] == m_o[d][n]) flip = 1'b0;
                    end
                    if (flip) begin
                        no[n] = ~m_o[d][n];
                        nr[n] = no[n];
                        nf[n] = ~no[n];
                    end
                end
                m_o[d] <= no;
                m_r[d] <= nr;
                m_f[d] <= nf;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            cmp("dut0_data", od0, m_o[0]);
            cmp("dut0_rise", or0, m_r[0]);
            cmp("dut0_fall", of0, m_f[0]);
            cmp("dut1_data", od1, m_o[1]);
            cmp("dut1_rise", or1, m_r[1]);
            cmp("dut1_fall", of1, m_f[1]);
        end
    end

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        din = 4'h0;
        edges(2);
        cmp("rst_od0", od0, 4'h0);
        cmp("rst_od1", od1, 4'hF);
        cmp("rst_or0", or0, 4'h0);
        rst = 1'b0;
        edges(2);
        cmp("f1_od1_e2", od1, 4'hF);
        cmp("f1_of1_e2", of1, 4'h0);
        edges(1);
        cmp("f1_od1_e3", od1, 4'h0);
        cmp("f1_of1_e3", of1, 4'hF);
        cmp("same_rst_or0", or0, 4'h0);
        edges(1);
        cmp("f1_of1_e4", of1, 4'h0);
        rst = 1'b1;
        din = 4'hF;
        edges(2);
        cmp("r25_od0", od0, 4'h0);
        cmp("r25_or0", or0, 4'h0);
        rst = 1'b0;
        edges(1);
        cmp("r25_nopulse", or0 | of0, 4'h0);
        edges(3);
        cmp("r25_od0_e4", od0, 4'h0);
        edges(1);
        cmp("r25_od0_e5", od0, 4'hF);
        cmp("r25_or0_e5", or0, 4'hF);
        edges(1);
        cmp("r25_or0_e6", or0, 4'h0);
        rst = 1'b1;
        din = 4'h0;
        edges(1);
        rst = 1'b0;
        edges(6);
        din = 4'h1;
        edges(4);
        cmp("lat_od0_e4", od0, 4'h0);
        edges(1);
        cmp("lat_od0_e5", od0, 4'h1);
        cmp("lat_or0_e5", or0, 4'h1);
        edges(1);
        cmp("lat_or0_e6", or0, 4'h0);
        din = 4'h3;
        edges(2);
        din = 4'h1;
        edges(8);
        cmp("glitch_od0", od0, 4'h1);
        din = 4'hD;
        edges(10);
        cmp("ind_od0_up", od0, 4'hD);
        din = 4'h5;
        edges(5);
        cmp("ind_of0", of0, 4'h8);
        cmp("ind_od0", od0, 4'h5);
        edges(1);
        cmp("ind_of0_next", of0, 4'h0);
        cmp("ind_od0_next", od0, 4'h5);
        rst = 1'b1;
        din = 4'h0;
        edges(1);
        rst = 1'b0;
        edges(6);
        din = 4'h1;
        edges(3);
        rst = 1'b1;
        edges(1);
        cmp("mid_od0", od0, 4'h0);
        cmp("mid_or0", or0, 4'h0);
        rst = 1'b0;
        edges(1);
        cmp("mid_nopulse", or0 | of0, 4'h0);
        edges(3);
        cmp("mid_od0_e4", od0, 4'h0);
        edges(1);
        cmp("mid_od0_e5", od0, 4'h1);
        cmp("mid_or0_e5", or0, 4'h1);
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 4; n++)
                if ($urandom_range(3) == 0) din[n] = ~din[n];
            rst = ($urandom_range(199) == 0);
            edges(1);
        end
        rst = 1'b0;
        edges(8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
